// File: rtl/bf16_acc.sv
// Streaming BF16 dot-product accumulator: one element per 3 cycles (ACC/ADD/NORM),
// result held in OUT until the downstream handshake, which clears the accumulator.
module bf16_acc #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [15:0]      i_p,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [15:0]      o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  typedef enum logic [1:0] {ACC, ADD, NORM, OUT} state_t;

  state_t            state, state_nxt;
  logic [15:0]       op;
  logic              last_r;
  logic              acc_sign;
  logic [7:0]        acc_exp;
  logic [15:0]       acc_man;
  logic [CNT_W-1:0]  count;
  logic              sat;

  logic              op_sign;
  logic [7:0]        op_exp;
  logic [15:0]       op_man;
  logic              op_big;
  logic              big_sign;
  logic [7:0]        big_exp, small_exp, diff;
  logic [15:0]       big_man, small_man, small_sh, dif16;
  logic [16:0]       sum17;
  logic              add_sign, add_sat;
  logic [7:0]        add_exp;
  logic [15:0]       add_man;
  logic [4:0]        lzc;
  logic signed [9:0] norm_exp;
  logic [15:0]       norm_man;
  logic              norm_zero;

  assign i_ready = (state == ACC);
  assign o_count = count;
  assign o_sat   = sat;

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (i_valid) state_nxt = ADD;
      ADD:     state_nxt = NORM;
      NORM:    state_nxt = last_r ? OUT : ACC;
      OUT:     if (o_valid && o_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  // Align-and-add: operand order chosen by magnitude so subtraction never underflows.
  always_comb begin
    op_sign   = op[15];
    op_exp    = op[14:7];
    op_man    = {1'b1, op[6:0], 8'b0};
    op_big    = (op_exp > acc_exp) || ((op_exp == acc_exp) && (op_man > acc_man));
    big_sign  = op_big ? op_sign : acc_sign;
    big_exp   = op_big ? op_exp  : acc_exp;
    big_man   = op_big ? op_man  : acc_man;
    small_exp = op_big ? acc_exp : op_exp;
    small_man = op_big ? acc_man : op_man;
    diff      = big_exp - small_exp;
    small_sh  = (diff >= 8'd16) ? 16'h0 : (small_man >> diff[3:0]);
    sum17     = {1'b0, big_man} + {1'b0, small_sh};
    dif16     = big_man - small_sh;
    add_sign  = big_sign;
    add_exp   = big_exp;
    add_man   = sum17[15:0];
    add_sat   = 1'b0;
    if (acc_sign == op_sign) begin
      if (sum17[16]) begin
        add_man = sum17[16:1];
        add_exp = big_exp + 8'd1;
        add_sat = (big_exp == 8'hFE);
      end
    end else begin
      add_man = dif16;
      if (dif16 == 16'h0) begin
        add_sign = 1'b0;
        add_exp  = 8'h00;
      end
    end
  end

  always_comb begin
    lzc = 5'd16;
    for (int i = 0; i < 16; i++) begin
      if (acc_man[i]) lzc = 5'(15 - i);
    end
    norm_exp  = $signed({2'b00, acc_exp}) - $signed({5'b00000, lzc});
    norm_man  = acc_man << lzc;
    norm_zero = (acc_man == 16'h0) || (norm_exp <= 10'sd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ACC;
      op       <= 16'h0;
      last_r   <= 1'b0;
      acc_sign <= 1'b0;
      acc_exp  <= 8'h0;
      acc_man  <= 16'h0;
      count    <= '0;
      sat      <= 1'b0;
      o_valid  <= 1'b0;
      o_sum    <= 16'h0;
    end else begin
      state <= state_nxt;
      case (state)
        ACC: if (i_valid) begin
          op     <= i_p;
          last_r <= i_last;
          if (count != '1) count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ADD: if (!sat && op_exp != 8'h00) begin
          if (op_exp == 8'hFF || add_sat) begin
            sat      <= 1'b1;
            acc_sign <= (op_exp == 8'hFF) ? op_sign : add_sign;
            acc_exp  <= 8'hFF;
            acc_man  <= 16'hFFFF;
          end else begin
            acc_sign <= add_sign;
            acc_exp  <= add_exp;
            acc_man  <= add_man;
          end
        end
        NORM: if (!sat) begin
          if (norm_zero) begin
            acc_sign <= 1'b0;
            acc_exp  <= 8'h00;
            acc_man  <= 16'h0;
          end else begin
            acc_exp <= norm_exp[7:0];
            acc_man <= norm_man;
          end
        end
        OUT: begin
          // First OUT cycle registers the result; o_valid rises on the following edge.
          if (!o_valid) begin
            o_valid <= 1'b1;
            o_sum   <= sat ? {acc_sign, 8'hFF, 7'h7F} : {acc_sign, acc_exp, acc_man[14:8]};
          end else if (o_ready) begin
            o_valid  <= 1'b0;
            op       <= 16'h0;
            last_r   <= 1'b0;
            acc_sign <= 1'b0;
            acc_exp  <= 8'h00;
            acc_man  <= 16'h0;
            count    <= '0;
            sat      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_acc.sv
// Randomized and directed bench for bf16_acc against a value-level accumulation model.
module tb_bf16_acc;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [15:0]   i_p = 16'h0;
  logic          i_last = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic [15:0]   o_sum;
  logic [CW-1:0] o_count;
  logic          o_sat;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int r_lat = 0;
  logic [15:0] vq[$];

  // Model state: value = m_man * 2^(m_exp-127-15), m_man==0 means zero
  bit m_sign, m_sat;
  int m_exp, m_man, m_cnt;

  bf16_acc #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_p(i_p),
    .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready), .o_sum(o_sum),
    .o_count(o_count), .o_sat(o_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    m_sign = 0; m_sat = 0; m_exp = 0; m_man = 0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [15:0] p);
    int pe, pm, a, b, s, mag, e, sh;
    if (m_cnt < (1 << CW) - 1) m_cnt++;
    if (m_sat) return;
    pe = int'(p[14:7]);
    if (pe == 0) return;
    if (pe == 255) begin m_sat = 1; m_sign = p[15]; return; end
    pm = (128 + int'(p[6:0])) * 256;
    if (m_man == 0) begin m_sign = p[15]; m_exp = pe; m_man = pm; return; end
    if (m_exp >= pe) begin
      e = m_exp; a = m_man; sh = m_exp - pe; b = (sh >= 16) ? 0 : pm / (1 << sh);
    end else begin
      e = pe; b = pm; sh = pe - m_exp; a = (sh >= 16) ? 0 : m_man / (1 << sh);
    end
    s = (m_sign ? -a : a) + (p[15] ? -b : b);
    if (s == 0) begin m_sign = 0; m_exp = 0; m_man = 0; return; end
    m_sign = (s < 0);
    mag = (s < 0) ? -s : s;
    while (mag >= 65536) begin mag = mag / 2; e++; end
    while (mag < 32768) begin mag = mag * 2; e--; end
    if (e >= 255) m_sat = 1;
    else if (e <= 0) begin m_sign = 0; m_exp = 0; m_man = 0; end
    else begin m_exp = e; m_man = mag; end
  endtask

  function automatic logic [15:0] model_sum();
    logic [15:0] mm;
    logic [7:0]  me;
    mm = m_man[15:0];
    me = m_exp[7:0];
    if (m_sat) return {m_sign, 8'hFF, 7'h7F};
    if (m_man == 0) return 16'h0000;
    return {m_sign, me, mm[14:8]};
  endfunction

  function automatic logic [15:0] rand_bf16();
    int r;
    logic [7:0] e;
    r = $urandom_range(0, 99);
    if (r < 5) e = 8'h00;
    else if (r < 8) e = 8'hFF;
    else e = 8'($urandom_range(112, 143));
    return {1'($urandom_range(0, 1)), e, 7'($urandom_range(0, 127))};
  endfunction

  task automatic send(input logic [15:0] p, input bit last);
    bit ok;
    ok = 0;
    i_valid = 1; i_p = p; i_last = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (i_ready) ok = 1;
      @(posedge clk); #1;
    end
    last_acc_cyc = cyc;
    i_valid = 0; i_last = 0;
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: i_ready stayed %0b, required 1", i_ready);
    end
  endtask

  task automatic wait_valid();
    r_lat = 0;
    while (!o_valid && r_lat < 20) begin @(posedge clk); #1; r_lat++; end
    if (!o_valid) begin
      errors++; checks++;
      $display("FAIL valid_timeout: o_valid=%0b after %0d edges, required 1", o_valid, r_lat);
    end
  endtask

  task automatic handshake();
    o_ready = 1; @(posedge clk); #1; o_ready = 0;
  endtask

  task automatic run_vec();
    model_reset();
    foreach (vq[i]) begin
      send(vq[i], i == vq.size() - 1);
      model_step(vq[i]);
    end
    wait_valid();
  endtask

  task automatic test_reset();
    #1 rst = 1; #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
    checks++; if (o_sum !== 16'h0) begin errors++; $display("FAIL rst_sum: got %h want 0000", o_sum); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", o_count); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %0b want 0", o_sat); end
    repeat (2) @(posedge clk);
    #1 rst = 0; #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0b want 1", i_ready); end
  endtask

  task automatic test_directed();
    vq = '{16'h3F80, 16'h3F80}; run_vec();
    checks++; if (o_sum !== 16'h4000) begin errors++; $display("FAIL one_plus_one: got %h want 4000", o_sum); end
    checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL one_plus_one_cnt: got %0d want 2", o_count); end
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL one_plus_one_sat: got %0b want 0", o_sat); end
    checks++; if (r_lat != 3) begin errors++; $display("FAIL latency: got %0d edges want 3", r_lat); end
    handshake();
    vq = '{16'h3F80, 16'hBF80}; run_vec();
    checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL cancel: got %h want 0000", o_sum); end
    checks++; if (o_count !== 3'd2) begin errors++; $display("FAIL cancel_cnt: got %0d want 2", o_count); end
    handshake();
    vq = '{16'h3F80, 16'h3380}; run_vec();
    checks++; if (o_sum !== 16'h3F80) begin errors++; $display("FAIL far_align: got %h want 3F80", o_sum); end
    handshake();
    vq = '{16'h0012}; run_vec();
    checks++; if (o_sum !== 16'h0000) begin errors++; $display("FAIL denorm_flush: got %h want 0000", o_sum); end
    checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL denorm_cnt: got %0d want 1", o_count); end
    handshake();
    vq = '{16'h7F7F, 16'h7F7F}; run_vec();
    checks++; if (o_sum !== 16'h7FFF) begin errors++; $display("FAIL ovf_sum: got %h want 7FFF", o_sum); end
    checks++; if (o_sat !== 1'b1) begin errors++; $display("FAIL ovf_sat: got %0b want 1", o_sat); end
    handshake();
    checks++; if (o_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b want 0", o_sat); end
    checks++; if (o_count !== '0) begin errors++; $display("FAIL cnt_clear: got %0d want 0", o_count); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL post_hs_ready: got %0b want 1", i_ready); end
  endtask

  task automatic test_hold();
    logic [15:0] es;
    vq = '{16'h4000, 16'h3F80}; run_vec();
    es = model_sum();
    i_valid = 1; i_last = 1;
    for (int k = 0; k < 5; k++) begin
      i_p = rand_bf16();
      @(posedge clk); #1;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %0b want 1", k, o_valid); end
      checks++; if (o_sum !== es) begin errors++; $display("FAIL hold_sum[%0d]: got %h want %h", k, o_sum, es); end
      checks++; if (int'(o_count) != m_cnt) begin errors++; $display("FAIL hold_cnt[%0d]: got %0d want %0d", k, o_count, m_cnt); end
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %0b want 0", k, i_ready); end
    end
    i_valid = 0; i_last = 0;
    handshake();
  endtask

  task automatic test_back_to_back();
    int prev;
    model_reset();
    prev = 0;
    for (int k = 0; k < 9; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      vq = '{16'h3F80};
      send(16'h3F80, k == 8);
      model_step(16'h3F80);
      if (k > 0) begin
        checks++;
        if (last_acc_cyc - prev < 3) begin errors++; $display("FAIL spacing[%0d]: got %0d cycles want >=3", k, last_acc_cyc - prev); end
      end
      prev = last_acc_cyc;
    end
    wait_valid();
    checks++; if (int'(o_count) != 7) begin errors++; $display("FAIL cnt_saturate: got %0d want 7", o_count); end
    checks++; if (o_sum !== model_sum()) begin errors++; $display("FAIL burst_sum: got %h want %h", o_sum, model_sum()); end
    handshake();
  endtask

  task automatic test_reset_mid();
    model_reset();
    send(16'h3F80, 0);
    send(16'h3F80, 0);
    #1 rst = 1; #1;
    checks++; if (o_count !== '0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", o_count); end
    #1 rst = 0; #1;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %0b want 1", i_ready); end
    vq = '{16'h4000}; run_vec();
    checks++; if (o_sum !== 16'h4000) begin errors++; $display("FAIL mid_rst_sum: got %h want 4000", o_sum); end
    checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL mid_rst_cnt2: got %0d want 1", o_count); end
    handshake();
  endtask

  task automatic test_random();
    int n;
    for (int v = 0; v < 40; v++) begin
      n = $urandom_range(1, 6);
      vq.delete();
      for (int k = 0; k < n; k++) vq.push_back(rand_bf16());
      if ($urandom_range(0, 3) == 0 && n >= 2) vq[1] = {~vq[0][15], vq[0][14:0]} ^ 16'($urandom_range(0, 3));
      run_vec();
      checks++; if (o_sum !== model_sum()) begin errors++; $display("FAIL rand_sum[%0d]: got %h want %h", v, o_sum, model_sum()); end
      checks++; if (int'(o_count) != m_cnt) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", v, o_count, m_cnt); end
      checks++; if (o_sat !== m_sat) begin errors++; $display("FAIL rand_sat[%0d]: got %0b want %0b", v, o_sat, m_sat); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
